// File: rtl/deltasigma_ctrl.sv
// Sequencer for a single-bit delta-sigma DAC modulator: trig prescaler, OSR sample hold and
// valid/ready double buffer. Define DELTASIGMA_CTRL_UNDERRUN_ZERO_EN to output zero on underrun.
module deltasigma_ctrl #(
  parameter int unsigned NB_BIT      = 32,
  parameter int unsigned PRESC_WIDTH = 16,
  parameter int unsigned OSR_WIDTH   = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   enable_i,
  input  logic [PRESC_WIDTH-1:0] prescaler_i,
  input  logic [OSR_WIDTH-1:0]   osr_i,
  input  logic [NB_BIT-1:0]      data_i,
  input  logic                   data_en_i,
  output logic                   data_rdy_o,
  output logic                   ds_rst_o,
  output logic                   trig_o,
  output logic [NB_BIT-1:0]      data_o,
  output logic                   busy_o,
  output logic                   underrun_o,
  input  logic                   underrun_clr_i
);

  typedef enum logic [1:0] {StIdle, StPrime, StRun, StStop} state_e;

  state_e                 r_state;
  logic [PRESC_WIDTH-1:0] r_prescaler;
  logic [PRESC_WIDTH-1:0] r_presc_cnt;
  logic [OSR_WIDTH-1:0]   r_osr;
  logic [OSR_WIDTH-1:0]   r_osr_cnt;
  logic [NB_BIT-1:0]      r_active;
  logic [NB_BIT-1:0]      r_pending;
  logic                   r_pend_valid;
  logic                   r_underrun;

  logic w_running;
  logic w_trig;
  logic w_boundary;
  logic w_accept;
  logic w_underrun;

  assign w_running  = (r_state == StRun) || (r_state == StStop);
  assign w_trig     = w_running && (r_presc_cnt == '0);
  assign w_boundary = w_trig && (r_osr_cnt == '0);
  assign data_rdy_o = !r_pend_valid && ((r_state == StPrime) || (r_state == StRun));
  assign w_accept   = data_en_i && data_rdy_o;
  // A word accepted on the boundary itself bypasses into active and is not an underrun.
  assign w_underrun = (r_state == StRun) && w_boundary && !r_pend_valid && !w_accept;

  assign ds_rst_o   = !w_running;
  assign trig_o     = w_trig;
  assign data_o     = r_active;
  assign busy_o     = (r_state != StIdle);
  assign underrun_o = r_underrun;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state      <= StIdle;
      r_prescaler  <= '0;
      r_presc_cnt  <= '0;
      r_osr        <= '0;
      r_osr_cnt    <= '0;
      r_active     <= '0;
      r_pending    <= '0;
      r_pend_valid <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      if (w_underrun) begin
        r_underrun <= 1'b1;
      end else if (underrun_clr_i) begin
        r_underrun <= 1'b0;
      end

      if (w_running) begin
        if (w_trig) begin
          r_presc_cnt <= r_prescaler;
          r_osr_cnt   <= w_boundary ? r_osr : r_osr_cnt - 1'b1;
        end else begin
          r_presc_cnt <= r_presc_cnt - 1'b1;
        end
      end

      unique case (r_state)
        StIdle: begin
          if (enable_i) begin
            r_prescaler <= prescaler_i;
            r_osr       <= osr_i;
            r_state     <= StPrime;
          end
        end
        StPrime: begin
          if (!enable_i) begin
            r_pend_valid <= 1'b0;
            r_state      <= StIdle;
          end else if (r_pend_valid) begin
            r_active     <= r_pending;
            r_pend_valid <= 1'b0;
            r_presc_cnt  <= r_prescaler;
            r_osr_cnt    <= r_osr;
            r_state      <= StRun;
          end else if (w_accept) begin
            r_pending    <= data_i;
            r_pend_valid <= 1'b1;
          end
        end
        StRun: begin
          if (w_boundary) begin
            if (r_pend_valid) begin
              r_active     <= r_pending;
              r_pend_valid <= 1'b0;
            end else if (w_accept) begin
              r_active <= data_i;
            end else begin
`ifdef DELTASIGMA_CTRL_UNDERRUN_ZERO_EN
              r_active <= '0;
`else
              r_active <= r_active;
`endif
            end
          end else if (w_accept) begin
            r_pending    <= data_i;
            r_pend_valid <= 1'b1;
          end
          if (!enable_i) begin
            r_state <= StStop;
          end
        end
        StStop: begin
          // Finish the current OSR period, then park the modulator at zero.
          if (w_boundary) begin
            r_active     <= '0;
            r_pend_valid <= 1'b0;
            r_state      <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_deltasigma_ctrl.sv
// Self-checking bench for deltasigma_ctrl: randomized runs checked against an arithmetic
// model of trig timing (period P+1) and sample hold (O+1 trigs per sample).
module tb_deltasigma_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        enable_i;
  logic [15:0] prescaler_i;
  logic [15:0] osr_i;
  logic [31:0] data_i;
  logic        data_en_i;
  logic        data_rdy_o;
  logic        ds_rst_o;
  logic        trig_o;
  logic [31:0] data_o;
  logic        busy_o;
  logic        underrun_o;
  logic        underrun_clr_i;

  int          n_vec;
  int          n_err;
  logic [31:0] samples [64];
  int unsigned g_p;
  int unsigned g_k;

  deltasigma_ctrl #(
    .NB_BIT     (32),
    .PRESC_WIDTH(16),
    .OSR_WIDTH  (16)
  ) dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .enable_i      (enable_i),
    .prescaler_i   (prescaler_i),
    .osr_i         (osr_i),
    .data_i        (data_i),
    .data_en_i     (data_en_i),
    .data_rdy_o    (data_rdy_o),
    .ds_rst_o      (ds_rst_o),
    .trig_o        (trig_o),
    .data_o        (data_o),
    .busy_o        (busy_o),
    .underrun_o    (underrun_o),
    .underrun_clr_i(underrun_clr_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_n_i        = 1'b0;
    enable_i       = 1'b0;
    data_en_i      = 1'b0;
    underrun_clr_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    next_cycle();
  endtask

  // Enables from IDLE; leaves the bench at the start of RUN cycle 0 with samples[0] loaded.
  task automatic start_run(input int unsigned p, input int unsigned o, input bit feed);
    prescaler_i = 16'(p);
    osr_i       = 16'(o);
    enable_i    = 1'b1;
    data_en_i   = 1'b1;
    data_i      = samples[0];
    next_cycle();
    prescaler_i = 16'($urandom);
    osr_i       = 16'($urandom);
    next_cycle();
    if (feed) data_i = samples[1];
    else data_en_i = 1'b0;
    next_cycle();
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    n_vec++; if (ds_rst_o !== 1'b1) begin n_err++; $display("FAIL reset_ds_rst: got %b want 1", ds_rst_o); end
    n_vec++; if (trig_o !== 1'b0) begin n_err++; $display("FAIL reset_trig: got %b want 0", trig_o); end
    n_vec++; if (data_o !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h want 0", data_o); end
    n_vec++; if (data_rdy_o !== 1'b0) begin n_err++; $display("FAIL reset_rdy: got %b want 0", data_rdy_o); end
    n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    n_vec++; if (underrun_o !== 1'b0) begin n_err++; $display("FAIL reset_underrun: got %b want 0", underrun_o); end
    next_cycle();
  endtask

  task automatic test_basic(input int unsigned p, input int unsigned o, input int unsigned ncyc);
    int unsigned sent;
    int unsigned idx;
    bit          acc;
    bit          exp_trig;
    prescaler_i = 16'(p);
    osr_i       = 16'(o);
    enable_i    = 1'b1;
    data_en_i   = 1'b1;
    data_i      = samples[0];
    @(negedge clk_i);
    n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL basic_idle_busy: got %b want 0", busy_o); end
    next_cycle();
    prescaler_i = 16'($urandom);
    osr_i       = 16'($urandom);
    @(negedge clk_i);
    n_vec++; if (ds_rst_o !== 1'b1) begin n_err++; $display("FAIL basic_prime_ds_rst: got %b want 1", ds_rst_o); end
    n_vec++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL basic_prime_busy: got %b want 1", busy_o); end
    n_vec++; if (data_rdy_o !== 1'b1) begin n_err++; $display("FAIL basic_prime_rdy: got %b want 1", data_rdy_o); end
    next_cycle();
    sent   = 1;
    data_i = samples[1];
    @(negedge clk_i);
    n_vec++; if (data_rdy_o !== 1'b0) begin n_err++; $display("FAIL basic_prime_full_rdy: got %b want 0", data_rdy_o); end
    next_cycle();
    for (int k = 0; k < int'(ncyc); k++) begin
      @(negedge clk_i);
      acc      = data_en_i && data_rdy_o;
      exp_trig = ((k + 1) % (p + 1)) == 0;
      idx      = (k / (p + 1)) / (o + 1);
      n_vec++; if (trig_o !== exp_trig) begin n_err++; $display("FAIL basic_trig p=%0d o=%0d k=%0d: got %b want %b", p, o, k, trig_o, exp_trig); end
      n_vec++; if (data_o !== samples[idx]) begin n_err++; $display("FAIL basic_data p=%0d o=%0d k=%0d: got %h want %h", p, o, k, data_o, samples[idx]); end
      n_vec++; if (ds_rst_o !== 1'b0) begin n_err++; $display("FAIL basic_ds_rst k=%0d: got %b want 0", k, ds_rst_o); end
      n_vec++; if (underrun_o !== 1'b0) begin n_err++; $display("FAIL basic_underrun k=%0d: got %b want 0", k, underrun_o); end
      next_cycle();
      if (acc) begin
        sent++;
        data_i = samples[sent % 64];
      end
    end
    do_reset();
  endtask

  task automatic test_bypass();
    int unsigned p;
    int unsigned o;
    int unsigned kb;
    logic [31:0] aa;
    p  = $urandom_range(0, 3);
    o  = $urandom_range(0, 2);
    kb = (p + 1) * (o + 1) - 1;
    aa = $urandom;
    start_run(p, o, 1'b0);
    for (int unsigned k = 0; k <= kb + 1; k++) begin
      data_en_i = (k == kb);
      data_i    = aa;
      @(negedge clk_i);
      if (k <= kb) begin
        n_vec++; if (data_o !== samples[0]) begin n_err++; $display("FAIL bypass_hold k=%0d: got %h want %h", k, data_o, samples[0]); end
      end
      if (k == kb) begin
        n_vec++; if (trig_o !== 1'b1) begin n_err++; $display("FAIL bypass_trig: got %b want 1", trig_o); end
        n_vec++; if (data_rdy_o !== 1'b1) begin n_err++; $display("FAIL bypass_rdy: got %b want 1", data_rdy_o); end
      end
      if (k == kb + 1) begin
        n_vec++; if (data_o !== aa) begin n_err++; $display("FAIL bypass_data: got %h want %h", data_o, aa); end
        n_vec++; if (underrun_o !== 1'b0) begin n_err++; $display("FAIL bypass_underrun: got %b want 0", underrun_o); end
      end
      next_cycle();
    end
    data_en_i = 1'b0;
    do_reset();
  endtask

  // Leaves the DUT running with underrun_o set; test_reset_mid_run continues from there.
  task automatic test_underrun();
    int unsigned o;
    int unsigned l;
    int unsigned kb;
    logic [31:0] exp_hold;
    g_p = $urandom_range(1, 3);
    o   = $urandom_range(0, 2);
    l   = (g_p + 1) * (o + 1);
    kb  = l - 1;
`ifdef DELTASIGMA_CTRL_UNDERRUN_ZERO_EN
    exp_hold = 32'h0;
`else
    exp_hold = samples[0];
`endif
    start_run(g_p, o, 1'b0);
    for (int unsigned k = 0; k <= 2 * l + 1; k++) begin
      underrun_clr_i = (k == kb + 1) || (k == 2 * l - 1);
      @(negedge clk_i);
      if (k <= kb) begin
        n_vec++; if (data_o !== samples[0]) begin n_err++; $display("FAIL underrun_pre_data k=%0d: got %h want %h", k, data_o, samples[0]); end
        n_vec++; if (underrun_o !== 1'b0) begin n_err++; $display("FAIL underrun_pre_flag k=%0d: got %b want 0", k, underrun_o); end
      end else begin
        n_vec++; if (data_o !== exp_hold) begin n_err++; $display("FAIL underrun_hold k=%0d: got %h want %h", k, data_o, exp_hold); end
      end
      if (k == kb + 1) begin
        n_vec++; if (underrun_o !== 1'b1) begin n_err++; $display("FAIL underrun_set: got %b want 1", underrun_o); end
      end
      if (k > kb + 1 && k <= 2 * l - 1) begin
        n_vec++; if (underrun_o !== 1'b0) begin n_err++; $display("FAIL underrun_clr k=%0d: got %b want 0", k, underrun_o); end
      end
      if (k >= 2 * l) begin
        n_vec++; if (underrun_o !== 1'b1) begin n_err++; $display("FAIL underrun_set_wins k=%0d: got %b want 1", k, underrun_o); end
      end
      next_cycle();
    end
    underrun_clr_i = 1'b0;
    g_k = 2 * l + 2;
  endtask

  task automatic test_reset_mid_run();
    for (int i = 0; i < 8 && ((g_k + 1) % (g_p + 1)) != 0; i++) begin
      next_cycle();
      g_k++;
    end
    n_vec++; if (trig_o !== 1'b1) begin n_err++; $display("FAIL midrst_pre_trig: got %b want 1", trig_o); end
    n_vec++; if (underrun_o !== 1'b1) begin n_err++; $display("FAIL midrst_pre_underrun: got %b want 1", underrun_o); end
    rst_n_i  = 1'b0;
    enable_i = 1'b0;
    #1;
    n_vec++; if (ds_rst_o !== 1'b1) begin n_err++; $display("FAIL midrst_ds_rst: got %b want 1", ds_rst_o); end
    n_vec++; if (trig_o !== 1'b0) begin n_err++; $display("FAIL midrst_trig: got %b want 0", trig_o); end
    n_vec++; if (data_o !== 32'h0) begin n_err++; $display("FAIL midrst_data: got %h want 0", data_o); end
    n_vec++; if (underrun_o !== 1'b0) begin n_err++; $display("FAIL midrst_underrun: got %b want 0", underrun_o); end
    n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b want 0", busy_o); end
    @(negedge clk_i);
    rst_n_i = 1'b1;
    next_cycle();
    @(negedge clk_i);
    n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL midrst_idle_busy: got %b want 0", busy_o); end
    n_vec++; if (ds_rst_o !== 1'b1) begin n_err++; $display("FAIL midrst_idle_ds_rst: got %b want 1", ds_rst_o); end
    next_cycle();
  endtask

  task automatic test_stop();
    int unsigned p;
    int unsigned k4;
    int unsigned k7;
    int unsigned sent;
    int unsigned idx;
    int unsigned stop_trigs;
    bit          acc;
    bit          exp_trig;
    p          = $urandom_range(0, 3);
    k4         = 5 * (p + 1) - 1;
    k7         = 8 * (p + 1) - 1;
    stop_trigs = 0;
    sent       = 1;
    start_run(p, 3, 1'b1);
    for (int unsigned k = 0; k <= k7 + 2; k++) begin
      if (k == k4 + 1) enable_i = 1'b0;
      @(negedge clk_i);
      acc = data_en_i && data_rdy_o;
      if (k <= k7) begin
        exp_trig = ((k + 1) % (p + 1)) == 0;
        idx      = (k / (p + 1)) / 4;
        n_vec++; if (trig_o !== exp_trig) begin n_err++; $display("FAIL stop_trig k=%0d: got %b want %b", k, trig_o, exp_trig); end
        n_vec++; if (data_o !== samples[idx]) begin n_err++; $display("FAIL stop_data k=%0d: got %h want %h", k, data_o, samples[idx]); end
        n_vec++; if (ds_rst_o !== 1'b0) begin n_err++; $display("FAIL stop_ds_rst k=%0d: got %b want 0", k, ds_rst_o); end
        n_vec++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL stop_busy k=%0d: got %b want 1", k, busy_o); end
        if (k > k4 && trig_o === 1'b1) stop_trigs++;
        if (k >= k4 + 2) begin
          n_vec++; if (data_rdy_o !== 1'b0) begin n_err++; $display("FAIL stop_rdy k=%0d: got %b want 0", k, data_rdy_o); end
        end
      end else begin
        n_vec++; if (data_o !== 32'h0) begin n_err++; $display("FAIL stop_end_data k=%0d: got %h want 0", k, data_o); end
        n_vec++; if (ds_rst_o !== 1'b1) begin n_err++; $display("FAIL stop_end_ds_rst k=%0d: got %b want 1", k, ds_rst_o); end
        n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL stop_end_busy k=%0d: got %b want 0", k, busy_o); end
        n_vec++; if (trig_o !== 1'b0) begin n_err++; $display("FAIL stop_end_trig k=%0d: got %b want 0", k, trig_o); end
      end
      next_cycle();
      if (acc) begin
        sent++;
        data_i = samples[sent % 64];
      end
    end
    n_vec++; if (stop_trigs != 3) begin n_err++; $display("FAIL stop_trig_count: got %0d want 3", stop_trigs); end
    do_reset();
  endtask

  initial begin
    n_vec          = 0;
    n_err          = 0;
    rst_n_i        = 1'b0;
    enable_i       = 1'b0;
    prescaler_i    = '0;
    osr_i          = '0;
    data_i         = '0;
    data_en_i      = 1'b0;
    underrun_clr_i = 1'b0;
    g_p            = 1;
    g_k            = 0;
    for (int i = 0; i < 64; i++) samples[i] = $urandom;
    samples[0] = samples[0] | 32'h1;
    do_reset();
    test_reset();
    test_basic(3, 1, 40);
    test_basic(0, 0, 48);
    for (int i = 0; i < 3; i++) test_basic($urandom_range(0, 4), $urandom_range(0, 3), 48);
    test_bypass();
    test_bypass();
    test_underrun();
    test_reset_mid_run();
    test_stop();
    test_stop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
